fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, is the number of cycles in REQ+WAIT without response before a timeout fault (legal range 1..255).
REQ-002 Parameter: NOP_INSTR, default 32'h00000013, is the instruction word presented on any fault.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 enabled  in  1  start-fetch strobe from core control.
REQ-006 pc  in  32  byte address to fetch, sampled with enabled.
REQ-007 mem_req  out  1  instruction-memory read request.
REQ-008 mem_addr  out  32  request address.
REQ-009 mem_gnt  in  1  memory accepts request this cycle.
REQ-010 mem_rvalid  in  1  read data valid.
REQ-011 mem_rdata  in  32  read data.
REQ-012 completed  out  1  one-cycle done pulse to core.
REQ-013 pc_out  out  32  pc of the fetched word, to decode.
REQ-014 instr_raw  out  32  fetched instruction, to decode.
REQ-015 fault  out  1  fetch failed; valid with completed.
REQ-016 fault_cause  out  2  00 none, 01 misaligned, 10 timeout.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DONE; all outputs registered.
REQ-018 IDLE: on enabled=1, latch pc; if pc[1:0]!=0 go DONE with fault=1, cause=01, instr_raw=NOP_INSTR, and issue no request; else go REQ.
REQ-019 REQ: mem_req=1, mem_addr=latched pc, both held stable until a cycle with mem_gnt=1; that cycle ends the request.
REQ-020 After mem_gnt: if mem_rvalid=1 in the same cycle, capture mem_rdata and go DONE; else go WAIT with mem_req=0.
REQ-021 WAIT: on mem_rvalid=1, capture mem_rdata into instr_raw, fault=0, cause=00, go DONE.
REQ-022 An 8-bit timeout counter clears on leaving IDLE and increments each cycle in REQ or WAIT; on reaching TIMEOUT_CYCLES without a response, go DONE with fault=1, cause=10, instr_raw=NOP_INSTR, and drop mem_req.
REQ-023 DONE: completed=1 for exactly one cycle, pc_out=latched pc; next state IDLE.
REQ-024 Latency: with enabled in cycle 0 and mem_gnt plus mem_rvalid in cycle 1, completed=1 in cycle 2; each additional wait cycle adds one cycle.
REQ-025 enabled is ignored in REQ, WAIT and DONE; there is no queuing.
REQ-026 mem_rvalid is ignored in IDLE, REQ-before-grant and DONE; a stray response never alters instr_raw.
REQ-027 pc_out, instr_raw, fault and fault_cause hold their values from the last completed until the next completed.
REQ-028 A timeout and mem_rvalid in the same cycle resolve to success, with the data captured.

Reset
REQ-029 rstn=0 forces, asynchronously, state=IDLE, mem_req=0, mem_addr=0, completed=0, pc_out=0, instr_raw=NOP_INSTR, fault=0, fault_cause=00, counter=0.
REQ-030 Reset mid-fetch abandons the transaction; a response arriving after rstn rises is ignored per REQ-026.

Verification
REQ-031 pc=0x8, enabled pulse, mem_gnt=1 plus mem_rvalid=1 with rdata=0x002181B3 in the next cycle -> completed pulse 2 cycles after enabled, pc_out=0x8, instr_raw=0x002181B3, fault=0.
REQ-032 mem_gnt delayed 3 cycles, then mem_rvalid 2 cycles later -> mem_addr stable throughout REQ, mem_req low in WAIT, completed exactly 1 cycle after mem_rvalid.
REQ-033 pc=0x6 -> no mem_req ever, completed 2 cycles after enabled, fault=1, cause=01, instr_raw=0x00000013.
REQ-034 TIMEOUT_CYCLES=4, mem_gnt=1, no mem_rvalid -> fault=1, cause=10 after 4 counted cycles; a later mem_rvalid changes nothing.
REQ-035 rstn pulsed low in WAIT -> mem_req=0 and state=IDLE immediately, without a clock edge; a late mem_rvalid gives no completed.
REQ-036 enabled held high through a whole fetch -> exactly one completed per IDLE entry, with the pc re-sampled only in IDLE.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: core-control and instruction-memory signals of the fetch unit
interface fetch_if;
    logic        enabled;
    logic [31:0] pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        completed;
    logic [31:0] pc_out;
    logic [31:0] instr_raw;
    logic        fault;
    logic [1:0]  fault_cause;

    // fetch unit side
    modport master (
        input  enabled, pc, mem_gnt, mem_rvalid, mem_rdata,
        output mem_req, mem_addr, completed, pc_out, instr_raw, fault, fault_cause
    );

    // core/memory side
    modport slave (
        output enabled, pc, mem_gnt, mem_rvalid, mem_rdata,
        input  mem_req, mem_addr, completed, pc_out, instr_raw, fault, fault_cause
    );
endinterface

// File: rtl/fetch.sv
// fetch: single-word instruction fetch FSM with misalignment and timeout faults
module fetch #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input logic    clk,
    input logic    rstn,
    fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [7:0]  r_cnt;
    logic        r_mis;
    logic        r_mem_req;
    logic        r_completed;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr;
    logic        r_fault;
    logic [1:0]  r_cause;

    logic w_ok;
    logic w_to;
    logic w_mf;
    logic w_fin;

    // A response only counts in WAIT or in the granting REQ cycle; it beats a coincident timeout
    assign w_ok  = !r_mis && bus.mem_rvalid && (r_state == WAIT || (r_state == REQ && bus.mem_gnt));
    assign w_to  = !r_mis && (r_state == REQ || r_state == WAIT) && !w_ok
                   && (r_cnt + 8'd1 == 8'(TIMEOUT_CYCLES));
    // A misaligned pc spends one bubble cycle in REQ with no request, then reports its fault
    assign w_mf  = r_state == REQ && r_mis;
    assign w_fin = w_ok || w_to || w_mf;

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_pc;
    assign bus.completed   = r_completed;
    assign bus.pc_out      = r_pc_out;
    assign bus.instr_raw   = r_instr;
    assign bus.fault       = r_fault;
    assign bus.fault_cause = r_cause;

    // FSM with registered outputs; a finishing cycle overrides the per-state updates
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_cnt       <= '0;
            r_mis       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_completed <= 1'b0;
            r_pc_out    <= '0;
            r_instr     <= NOP_INSTR;
            r_fault     <= 1'b0;
            r_cause     <= 2'b00;
        end else begin
            r_completed <= 1'b0;
            case (r_state)
                IDLE: if (bus.enabled) begin
                    r_pc      <= bus.pc;
                    r_cnt     <= '0;
                    r_mis     <= |bus.pc[1:0];
                    r_mem_req <= ~|bus.pc[1:0];
                    r_state   <= REQ;
                end
                REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (bus.mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: r_cnt <= r_cnt + 8'd1;
                DONE: r_state <= IDLE;
            endcase
            if (w_fin) begin
                r_state     <= DONE;
                r_mem_req   <= 1'b0;
                r_completed <= 1'b1;
                r_pc_out    <= r_pc;
                r_instr     <= w_ok ? bus.mem_rdata : NOP_INSTR;
                r_fault     <= !w_ok;
                r_cause     <= w_ok ? 2'b00 : (w_mf ? 2'b01 : 2'b10);
            end
        end
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scoreboard bench for fetch; unit 0 uses default timeout, unit 1 uses 4
module tb_fetch;
    logic clk;
    logic rstn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          u;
        int          cyc;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] f;
        logic [31:0] c;
    } exp_t;
    exp_t q[$];

    fetch_if a();
    fetch_if b();

    fetch dut_a (.clk(clk), .rstn(rstn), .bus(a));
    fetch #(.TIMEOUT_CYCLES(4)) dut_b (.clk(clk), .rstn(rstn), .bus(b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_done(int u, int dc, logic [31:0] pc, logic [31:0] ins, logic [31:0] f, logic [31:0] c);
        exp_t e;
        e.u = u; e.cyc = cyc + dc; e.pc = pc; e.ins = ins; e.f = f; e.c = c;
        q.push_back(e);
    endtask

    task automatic pop(int u);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected completed: unit %0d at cycle %0d, none expected", u, cyc);
        end else begin
            e = q.pop_front();
            chk("unit", u, e.u);
            chk("cycle", cyc, e.cyc);
            chk("pc_out", u ? b.pc_out : a.pc_out, e.pc);
            chk("instr_raw", u ? b.instr_raw : a.instr_raw, e.ins);
            chk("fault", 32'(u ? b.fault : a.fault), e.f);
            chk("fault_cause", 32'(u ? b.fault_cause : a.fault_cause), e.c);
        end
    endtask

    // monitor: every completed pulse must match the oldest expected result
    always @(negedge clk) begin
        if (a.completed) pop(0);
        if (b.completed) pop(1);
    end

    initial begin
        clk = 0; rstn = 0;
        a.enabled = 0; a.pc = 0; a.mem_gnt = 0; a.mem_rvalid = 0; a.mem_rdata = 0;
        b.enabled = 0; b.pc = 0; b.mem_gnt = 0; b.mem_rvalid = 0; b.mem_rdata = 0;
        step(2);
        chk("rst mem_req", 32'(a.mem_req), 0);
        chk("rst mem_addr", a.mem_addr, 0);
        chk("rst completed", 32'(a.completed), 0);
        chk("rst pc_out", a.pc_out, 0);
        chk("rst instr_raw", a.instr_raw, 32'h13);
        chk("rst fault", 32'(a.fault), 0);
        chk("rst cause", 32'(a.fault_cause), 0);
        chk("rst b instr_raw", b.instr_raw, 32'h13);
        rstn = 1;
        step();

        // single-cycle grant+response
        a.enabled = 1; a.pc = 32'h8;
        expect_done(0, 2, 32'h8, 32'h002181B3, 0, 0);
        step();
        a.enabled = 0;
        chk("t1 mem_req", 32'(a.mem_req), 1);
        chk("t1 mem_addr", a.mem_addr, 32'h8);
        a.mem_gnt = 1; a.mem_rvalid = 1; a.mem_rdata = 32'h002181B3;
        step();
        a.mem_gnt = 0; a.mem_rvalid = 0; a.mem_rdata = 0;
        step(2);

        // grant delayed 3 cycles, response 2 cycles after grant
        a.enabled = 1; a.pc = 32'h100;
        expect_done(0, 7, 32'h100, 32'h00A00093, 0, 0);
        step();
        a.enabled = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t2 req held", 32'(a.mem_req), 1);
            chk("t2 addr held", a.mem_addr, 32'h100);
            step();
        end
        chk("t2 req at gnt", 32'(a.mem_req), 1);
        a.mem_gnt = 1;
        step();
        a.mem_gnt = 0;
        chk("t2 req low wait", 32'(a.mem_req), 0);
        step();
        chk("t2 req low wait2", 32'(a.mem_req), 0);
        a.mem_rvalid = 1; a.mem_rdata = 32'h00A00093;
        step();
        a.mem_rvalid = 0;
        step(2);

        // misaligned pc with stray memory activity
        a.enabled = 1; a.pc = 32'h6; a.mem_gnt = 1; a.mem_rvalid = 1; a.mem_rdata = 32'hDEADBEEF;
        expect_done(0, 2, 32'h6, 32'h13, 1, 1);
        step();
        a.enabled = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t3 no req", 32'(a.mem_req), 0);
            step();
        end
        chk("t3 stray ignored", a.instr_raw, 32'h13);
        a.mem_gnt = 0; a.mem_rvalid = 0;
        step();

        // timeout in WAIT, late response ignored
        b.enabled = 1; b.pc = 32'h40;
        expect_done(1, 5, 32'h40, 32'h13, 1, 2);
        step();
        b.enabled = 0; b.mem_gnt = 1;
        step();
        b.mem_gnt = 0;
        step(3);
        chk("t4 req dropped", 32'(b.mem_req), 0);
        step();
        b.mem_rvalid = 1; b.mem_rdata = 32'h12345678;
        step(2);
        b.mem_rvalid = 0;
        chk("t4 late instr", b.instr_raw, 32'h13);
        chk("t4 late fault", 32'(b.fault), 1);
        chk("t4 late cause", 32'(b.fault_cause), 2);

        // timeout in REQ without grant
        b.enabled = 1; b.pc = 32'h44;
        expect_done(1, 5, 32'h44, 32'h13, 1, 2);
        step();
        b.enabled = 0;
        step(3);
        chk("t4b req before to", 32'(b.mem_req), 1);
        step();
        chk("t4b req after to", 32'(b.mem_req), 0);
        step();

        // response coincides with timeout: success wins
        b.enabled = 1; b.pc = 32'h48;
        expect_done(1, 5, 32'h48, 32'h00B00113, 0, 0);
        step();
        b.enabled = 0; b.mem_gnt = 1;
        step();
        b.mem_gnt = 0;
        step(2);
        b.mem_rvalid = 1; b.mem_rdata = 32'h00B00113;
        step();
        b.mem_rvalid = 0;
        step(2);

        // asynchronous reset in WAIT, late response ignored
        a.enabled = 1; a.pc = 32'h20;
        step();
        a.enabled = 0; a.mem_gnt = 1;
        step();
        a.mem_gnt = 0;
        chk("t5 addr before rst", a.mem_addr, 32'h20);
        #2 rstn = 0;
        #1;
        chk("t5 async mem_req", 32'(a.mem_req), 0);
        chk("t5 async mem_addr", a.mem_addr, 0);
        chk("t5 async b pc_out", b.pc_out, 0);
        step();
        rstn = 1; a.mem_rvalid = 1; a.mem_rdata = 32'hCAFEF00D;
        step(2);
        a.mem_rvalid = 0;
        chk("t5 late instr", a.instr_raw, 32'h13);
        chk("t5 late pc_out", a.pc_out, 0);
        step();

        // enabled held high: one fetch per IDLE visit, pc sampled only in IDLE
        a.enabled = 1; a.pc = 32'h30; a.mem_gnt = 1; a.mem_rvalid = 1; a.mem_rdata = 32'h11111111;
        expect_done(0, 2, 32'h30, 32'h11111111, 0, 0);
        expect_done(0, 5, 32'h34, 32'h22222222, 0, 0);
        step();
        a.pc = 32'h34;
        step();
        a.mem_rdata = 32'h22222222;
        step(4);
        a.enabled = 0; a.mem_gnt = 0; a.mem_rvalid = 0;
        step(3);

        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missing completed: %0d outstanding, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
